// File: rtl/serial_add_sub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor and its bench.
// Holds the FSM state encoding, the default operand width and a signed-overflow helper.
package serial_add_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Overflow from operand/result sign bits; b_msb is the raw operand, inverted here for subtract.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic sub, input logic sum_msb);
    logic b_eff;
    b_eff = b_msb ^ sub;
    return (a_msb == b_eff) && (sum_msb != a_msb);
  endfunction

endpackage

// File: rtl/serial_add_sub_fa_cell.sv
// Single-bit full-adder cell, purely combinational.
// Kept standalone so the parallel adder variants can reuse it.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial two's-complement adder/subtractor: one full-adder cell, LSB first,
// WIDTH cycles per operation, registered sum/cout/ovf with a single-cycle done pulse.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic bit_s;
  logic bit_c;

  fa_cell u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .s    (bit_s),
    .cout (bit_c)
  );

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      IDLE, DONE: begin
        // Subtraction is a + ~b + 1: the +1 enters through the initial carry.
        if (start) begin
          a_sr_d   = a;
          b_sr_d   = sub ? ~b : b;
          res_sr_d = '0;
          carry_d  = sub;
          cnt_d    = '0;
          state_d  = RUN;
          busy_d   = 1'b1;
        end else begin
          state_d  = IDLE;
          busy_d   = 1'b0;
        end
      end
      RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        res_sr_d = {bit_s, res_sr_q[WIDTH-1:1]};
        carry_d  = bit_c;
        cnt_d    = cnt_q + CNT_W'(1);
        // On the MSB, carry_q is the carry into the MSB, so ovf is formed directly here.
        if (cnt_q == LAST_BIT) begin
          sum_d   = {bit_s, res_sr_q[WIDTH-1:1]};
          cout_d  = bit_c;
          ovf_d   = carry_q ^ bit_c;
          cnt_d   = '0;
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub at WIDTH 8, plus sweeps at WIDTH 2 and 32
// checked against a bench-side arithmetic model.
module tb_serial_add_sub;
  import serial_add_sub_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       start8, sub8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;

  logic       start2, sub2, busy2, done2, cout2, ovf2;
  logic [1:0] a2, b2, sum2;

  logic        start32, sub32, busy32, done32, cout32, ovf32;
  logic [31:0] a32, b32, sum32;

  int n_cmp = 0;
  int n_err = 0;

  serial_add_sub #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_add_sub #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
  );

  serial_add_sub #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .sub(sub32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .sum(sum32), .cout(cout32), .ovf(ovf32)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one WIDTH=8 operation and check the done cycle exactly WIDTH edges after start.
  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic s,
                      input logic [7:0] es, input logic ec, input logic eo, input string tag);
    logic early;
    early = 1'b0;
    a8 = av; b8 = bv; sub8 = s; start8 = 1'b1;
    step();
    start8 = 1'b0;
    chk({tag, "_busy"}, busy8, 1);
    for (int i = 1; i < 8; i++) begin
      step();
      if (done8 || !busy8) early = 1'b1;
    end
    chk({tag, "_early"}, early, 0);
    step();
    chk({tag, "_done"}, done8, 1);
    chk({tag, "_busy_at_done"}, busy8, 0);
    chk({tag, "_sum"}, sum8, es);
    chk({tag, "_cout"}, cout8, ec);
    chk({tag, "_ovf"}, ovf8, eo);
  endtask

  initial begin
    int          dones;
    logic [1:0]  bb2;
    logic [2:0]  r2;
    logic [31:0] bb32;
    logic [32:0] r32;

    rst_n = 1'b0;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    start2 = 1'b0; sub2 = 1'b0; a2 = '0; b2 = '0;
    start32 = 1'b0; sub32 = 1'b0; a32 = '0; b32 = '0;
    step();
    step();
    rst_n = 1'b1;

    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_sum", sum8, 0);
    chk("rst_cout", cout8, 0);
    chk("rst_ovf", ovf8, 0);

    run8(8'hC8, 8'h37, 1'b0, 8'hFF, 1'b0, 1'b0, "add_c8_37");
    step();
    chk("done_single_cycle", done8, 0);
    chk("sum_held_idle", sum8, 8'hFF);
    run8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "add_7f_01");
    step();
    run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
    step();
    run8(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_05_07");
    step();
    run8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_80_01");
    step();

    // Second start three bits into RUN must be ignored.
    dones = 0;
    a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done8) dones++;
    end
    a8 = 8'h55; b8 = 8'h66; sub8 = 1'b1; start8 = 1'b1;
    step();
    start8 = 1'b0;
    if (done8) dones++;
    chk("ign_sum_held_in_run", sum8, 8'h7F);
    for (int i = 0; i < 3; i++) begin
      step();
      if (done8) dones++;
    end
    step();
    chk("ign_early_done", dones, 0);
    chk("ign_done", done8, 1);
    chk("ign_sum", sum8, 8'h46);
    chk("ign_cout", cout8, 0);
    chk("ign_ovf", ovf8, 0);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done8) dones++;
    end
    chk("ign_no_second_done", dones, 0);

    // Back-to-back: the second start arrives in the DONE cycle of the first.
    run8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, "b2b_first");
    run8(8'h40, 8'h50, 1'b1, 8'hF0, 1'b0, 1'b0, "b2b_second");
    step();

    // Reset mid-RUN at bit 4 aborts without a done.
    a8 = 8'h5A; b8 = 8'h21; sub8 = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_sum", sum8, 0);
    chk("abort_cout", cout8, 0);
    chk("abort_ovf", ovf8, 0);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done8) dones++;
    end
    chk("abort_no_done", dones, 0);

    rst_n = 1'b0; start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; sub8 = 1'b0;
    step();
    rst_n = 1'b1; start8 = 1'b0;
    chk("rst_beats_start", busy8, 0);
    step();
    chk("rst_beats_start_idle", busy8, 0);

    run8(8'h5A, 8'h21, 1'b0, 8'h7B, 1'b0, 1'b0, "after_abort");
    step();

    // WIDTH=2 exhaustive sweep.
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        for (int s = 0; s < 2; s++) begin
          a2 = 2'(i); b2 = 2'(j); sub2 = s[0]; start2 = 1'b1;
          bb2 = sub2 ? ~b2 : b2;
          r2 = {1'b0, a2} + {1'b0, bb2} + {2'b00, sub2};
          step();
          start2 = 1'b0;
          chk("w2_busy", busy2, 1);
          step();
          step();
          chk("w2_done", done2, 1);
          chk("w2_sum", sum2, r2[1:0]);
          chk("w2_cout", cout2, r2[2]);
          chk("w2_ovf", ovf2, signed_ovf(a2[1], b2[1], sub2, r2[1]));
          step();
        end
      end
    end

    // WIDTH=32: corner operands first, then random operands.
    for (int k = 0; k < 14; k++) begin
      case (k)
        0:       begin a32 = 32'h7FFF_FFFF; b32 = 32'h0000_0001; sub32 = 1'b0; end
        1:       begin a32 = 32'h8000_0000; b32 = 32'h0000_0001; sub32 = 1'b1; end
        2:       begin a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; sub32 = 1'b0; end
        3:       begin a32 = 32'h0000_0000; b32 = 32'h0000_0000; sub32 = 1'b1; end
        default: begin a32 = $urandom; b32 = $urandom; sub32 = 1'($urandom_range(1)); end
      endcase
      bb32 = sub32 ? ~b32 : b32;
      r32 = {1'b0, a32} + {1'b0, bb32} + {32'd0, sub32};
      start32 = 1'b1;
      step();
      start32 = 1'b0;
      chk("w32_busy", busy32, 1);
      for (int i = 1; i < 32; i++) step();
      step();
      chk("w32_done", done32, 1);
      chk("w32_sum", sum32, r32[31:0]);
      chk("w32_cout", cout32, r32[32]);
      chk("w32_ovf", ovf32, signed_ovf(a32[31], b32[31], sub32, r32[31]));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
